imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder for the baseline core: the instruction-supply end of the core's `pc_out`/`instruction` fetch interface. A host streams a program in through a valid/ready load port. On `start`, the block releases the core from reset and answers every fetch address with the stored word, or a NOP outside the program. It ends the run when the core's PC runs past the last loaded word or a cycle budget expires.

## Interface
Parameters:
- `AW`, 8: word-address width; memory depth is 2^AW words (256).
- `NOP`, 32'h00000013: word returned for out-of-range or misaligned fetches.
- `MAX_CYCLES`, 16'hFFFF: run-cycle budget before forced stop.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  host offers `load_data`.
- `load_ready`  out  1  block accepts a word this cycle.
- `load_data`  in  32  program word.
- `load_last`  in  1  accompanies the final program word.
- `start`  in  1  one-cycle pulse; begin or re-run the loaded program.
- `clear`  in  1  one-cycle pulse; discard the program and return to IDLE.
- `pc_in`  in  32  fetch address from the core (`pc_out`).
- `instruction`  out  32  fetched word to the core.
- `core_rst`  out  1  reset to the core; high except in RUN.
- `done`  out  1  high in DONE.
- `fault`  out  1  sticky; set on a misaligned fetch or load overflow.
- `words_loaded`  out  AW+1  number of valid program words.
- `run_cycles`  out  16  cycles spent in the last/current RUN.

## Operation
- States: IDLE, READY, RUN, DONE. Encodings live in the shared package.
- IDLE:
  - `load_ready`=1. A word is accepted when `load_valid && load_ready`.
  - Each accepted word is written to `mem[wr_ptr]`, and `wr_ptr` increments.
  - An accept with `load_last`, or an accept that fills word 2^AW-1, moves to READY.
- Overflow: if `load_valid` is still high in READY without `clear`, `fault` is set and the word is dropped. `load_ready`=0 outside IDLE.
- `words_loaded` = `wr_ptr`, where `wr_ptr` is AW+1 bits and saturates at 2^AW.
- READY: `start` moves to RUN and zeroes `run_cycles`. `start` in IDLE is ignored; an empty program is impossible.
- RUN:
  - Fetch index is `idx = pc_in[AW+1:2]`.
  - Out of range is `pc_in[31:AW+2]!=0` or `idx>=words_loaded`.
  - `instruction` = `mem[idx]` when in range and `pc_in[1:0]==0`, else `NOP`.
  - `run_cycles` increments each RUN cycle.
- RUN exits to DONE on whichever occurs first:
  - The fetch is out of range. That fetch is still answered with `NOP`.
  - `run_cycles` reaches `MAX_CYCLES-1`.
- A misaligned `pc_in` in RUN sets `fault` and returns `NOP`, and RUN continues.
- DONE: `start` moves to RUN (re-run, same program, `run_cycles` zeroed).
- `clear` in any state moves to IDLE with `wr_ptr`=0. Memory contents are kept but unreachable; `fault` is cleared. `clear` has priority over `start`.
- Outside RUN, `instruction` = `NOP`.

## Timing
- Reset values: state IDLE, `load_ready`=1, `core_rst`=1, `done`=0, `fault`=0, `words_loaded`=0, `run_cycles`=0, `instruction`=`NOP`. Memory is not reset.
- `instruction` is combinational from `pc_in` and the memory, with zero-cycle latency, because the core decodes `instruction` in the same cycle it drives `pc_out`.
- The memory read is asynchronous; writes land on the clock edge.
- `core_rst` is a registered output:
  - It deasserts the cycle after `start` is sampled. That first RUN cycle sees the core's `pc`=0.
  - It reasserts the cycle after the exit condition is sampled.
- `load_ready` depends only on state, never on `load_valid`.
- The host may hold `load_valid` high across cycles; each cycle with `load_ready` high consumes one word.
- `done` asserts in the first DONE cycle and is registered.
- `rst` mid-load or mid-run behaves like `clear` but also clears `run_cycles`.
- Simultaneous events:
  - `clear` with a load accept: `clear` wins and the word is dropped.
  - RUN exit with `start` in the same cycle: the exit wins, and `start` is ignored.

## Structure
- Shared package `imem_pkg` holds:
  - the state enum/localparams `S_IDLE`, `S_READY`, `S_RUN`, `S_DONE`;
  - the `NOP` default and the opcode constant `OPC_BRANCH` = 7'b1100011, used by benches.
- One sub-module, `imem_ram`: 2^AW x 32, one synchronous write port and one asynchronous read port.
- The top level holds the FSM, counters and fetch mux.

## Test plan
- Load 4 words {addi, beq(32'h00000063), addi, addi} with `load_last` on the 4th, then `start`:
  - `words_loaded`=4.
  - `core_rst` falls 1 cycle after `start`.
  - `pc_in`=0,4,8,12 return words 0..3.
  - `pc_in`=16 returns `NOP`, then `done`=1 and `core_rst`=1.
- Load 2^AW=256 words with no `load_last`:
  - The block moves to READY after the 256th word, and `words_loaded`=256.
  - A 257th `load_valid` leaves `load_ready`=0 and sets `fault`=1.
- Fetch `pc_in`=32'h00000006 during RUN: `instruction`=32'h00000013, `fault`=1, state stays RUN.
- Run with `MAX_CYCLES`=8 and `pc_in` held at 0: DONE after exactly 8 RUN cycles, `run_cycles`=7, `done`=1.
- In DONE, pulse `start`: the run repeats with the same words and `run_cycles` restarts at 0.
  - Pulse `start` and `clear` together: the block reaches IDLE, `words_loaded`=0, `load_ready`=1.
- Assert `rst` for 1 cycle mid-RUN: next cycle all outputs are at their reset values, and `instruction`=`NOP` regardless of `pc_in`.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared states and constants for the instruction-memory responder and its benches.
package imem_pkg;
   typedef enum logic [1:0] {S_IDLE, S_READY, S_RUN, S_DONE} state_e;
   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
endpackage

// File: rtl/imem_if.sv
// imem_if: host load port, run control, core fetch port and status of the responder.
interface imem_if #(parameter int AW = 8) ();
   logic load_valid, load_ready, load_last, start, clear;
   logic [31:0] load_data, pc_in, instruction;
   logic core_rst, done, fault;
   logic [AW:0] words_loaded;
   logic [15:0] run_cycles;
   modport master (
      output load_valid, load_data, load_last, start, clear, pc_in,
      input load_ready, instruction, core_rst, done, fault, words_loaded, run_cycles
   );
   modport slave (
      input load_valid, load_data, load_last, start, clear, pc_in,
      output load_ready, instruction, core_rst, done, fault, words_loaded, run_cycles
   );
endinterface

// File: rtl/imem_ram.sv
// imem_ram: 2^AW x 32 program store, synchronous write, asynchronous read.
module imem_ram #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);
   logic [31:0] mem_q [2**AW];
   always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: loads a program from a host, then serves core fetches until the PC
// leaves the program or the cycle budget runs out.
module imem_responder
   import imem_pkg::*;
#(
   parameter int          AW         = 8,
   parameter logic [31:0] NOP        = NOP_DEFAULT,
   parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
   input logic   clk,
   input logic   rst,
   imem_if.slave bus
);
   state_e        state_q, state_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [15:0]   run_q, run_d;
   logic          fault_q, fault_d, core_rst_q, done_q;
   logic          accept, aligned, oor, exit_run;
   logic [AW-1:0] idx;
   logic [31:0]   rdata;

   assign idx      = bus.pc_in[AW+1:2];
   assign aligned  = bus.pc_in[1:0] == 2'b00;
   assign oor      = (bus.pc_in[31:AW+2] != '0) || ({1'b0, idx} >= wr_ptr_q);
   assign accept   = state_q == S_IDLE && bus.load_valid && !bus.clear;
   assign exit_run = oor || run_q == MAX_CYCLES - 16'd1;

   imem_ram #(.AW(AW)) u_ram (
      .clk(clk), .we_i(accept), .waddr_i(wr_ptr_q[AW-1:0]), .wdata_i(bus.load_data),
      .raddr_i(idx), .rdata_o(rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         run_q      <= '0;
         fault_q    <= 1'b0;
         core_rst_q <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         run_q      <= run_d;
         fault_q    <= fault_d;
         core_rst_q <= state_d != S_RUN;
         done_q     <= state_d == S_DONE;
      end
   end

   // The cycle that triggers the exit is not counted, so a budget of N leaves run_cycles at N-1.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      run_d    = run_q;
      fault_d  = fault_q;
      if (bus.clear) begin
         state_d  = S_IDLE;
         wr_ptr_d = '0;
         fault_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (accept) begin
               wr_ptr_d = wr_ptr_q + (AW+1)'(1);
               if (bus.load_last || &wr_ptr_q[AW-1:0]) state_d = S_READY;
            end
            S_READY: begin
               fault_d = fault_q | bus.load_valid;
               if (bus.start) begin
                  state_d = S_RUN;
                  run_d   = '0;
               end
            end
            S_RUN: begin
               fault_d = fault_q | !aligned;
               if (exit_run) state_d = S_DONE;
               else run_d = run_q + 16'd1;
            end
            S_DONE: if (bus.start) begin
               state_d = S_RUN;
               run_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      bus.load_ready  = state_q == S_IDLE;
      bus.instruction = (state_q == S_RUN && !oor && aligned) ? rdata : NOP;
   end

   assign bus.core_rst     = core_rst_q;
   assign bus.done         = done_q;
   assign bus.fault        = fault_q;
   assign bus.words_loaded = wr_ptr_q;
   assign bus.run_cycles   = run_q;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed scenarios plus random load/run traffic, checked every cycle
// against a word-array model of the responder.
module tb_imem_responder;
   import imem_pkg::*;
   localparam logic [15:0] MAXC = 16'd8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   imem_if #(.AW(8)) bus ();
   imem_responder #(.AW(8), .MAX_CYCLES(MAXC)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   bit chk_en = 1'b0;

   logic [31:0] mm [256];
   int n = 0, cyc = 0;
   bit loading = 1'b1, armed = 1'b0, running = 1'b0, finished = 1'b0, flt = 1'b0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_instr();
      if (running && bus.pc_in % 4 == 0 && bus.pc_in < 32'(4 * n)) return mm[int'(bus.pc_in / 4)];
      return NOP_DEFAULT;
   endfunction

   // Model: a word array with a fill count and a few phase flags.
   always @(posedge clk) begin
      if (rst) begin
         n <= 0; cyc <= 0; loading <= 1; armed <= 0; running <= 0; finished <= 0; flt <= 0;
      end else if (bus.clear) begin
         n <= 0; loading <= 1; armed <= 0; running <= 0; finished <= 0; flt <= 0;
      end else if (loading) begin
         if (bus.load_valid) begin
            mm[n] <= bus.load_data;
            n <= n + 1;
            if (bus.load_last || n == 255) begin loading <= 0; armed <= 1; end
         end
      end else if (armed) begin
         if (bus.load_valid) flt <= 1;
         if (bus.start) begin armed <= 0; running <= 1; cyc <= 0; end
      end else if (running) begin
         if (bus.pc_in % 4 != 0) flt <= 1;
         if (bus.pc_in >= 32'(4 * n) || cyc == int'(MAXC) - 1) begin running <= 0; finished <= 1; end
         else cyc <= cyc + 1;
      end else if (finished && bus.start) begin
         finished <= 0; running <= 1; cyc <= 0;
      end
   end

   always @(negedge clk) if (chk_en) begin
      check("load_ready", 32'(bus.load_ready), 32'(loading));
      check("instruction", bus.instruction, exp_instr());
      check("core_rst", 32'(bus.core_rst), 32'(!running));
      check("done", 32'(bus.done), 32'(finished));
      check("fault", 32'(bus.fault), 32'(flt));
      check("words_loaded", 32'(bus.words_loaded), 32'(n));
      check("run_cycles", 32'(bus.run_cycles), 32'(cyc));
   end

   logic [31:0] prog [4] = '{32'h00100093, 32'h00000063, 32'h00208113, 32'h00310193};
   logic [31:0] w;

   initial begin
      bus.load_valid = 0; bus.load_data = 0; bus.load_last = 0;
      bus.start = 0; bus.clear = 0; bus.pc_in = 0;
      tick(); tick();
      rst = 0;
      chk_en = 1;
      #1;
      check("rst_ready", 32'(bus.load_ready), 32'd1);
      check("rst_core_rst", 32'(bus.core_rst), 32'd1);
      check("rst_instr", bus.instruction, 32'h00000013);
      // four-word program
      for (int i = 0; i < 4; i++) begin
         bus.load_valid = 1; bus.load_data = prog[i]; bus.load_last = (i == 3);
         tick();
      end
      bus.load_valid = 0; bus.load_last = 0;
      check("lit_words4", 32'(bus.words_loaded), 32'd4);
      check("lit_ready_low", 32'(bus.load_ready), 32'd0);
      bus.start = 1; tick(); bus.start = 0;
      check("lit_core_rst_fall", 32'(bus.core_rst), 32'd0);
      for (int k = 0; k < 4; k++) begin
         bus.pc_in = 32'(4 * k); #1;
         check("lit_fetch", bus.instruction, prog[k]);
         tick();
      end
      bus.pc_in = 16; #1;
      check("lit_fetch_past_end", bus.instruction, 32'h00000013);
      tick();
      check("lit_done", 32'(bus.done), 32'd1);
      check("lit_core_rst_back", 32'(bus.core_rst), 32'd1);
      // re-run with a branch fetch and a misaligned fetch
      bus.start = 1; tick(); bus.start = 0;
      check("lit_rerun_cycles", 32'(bus.run_cycles), 32'd0);
      bus.pc_in = 4; #1;
      w = bus.instruction;
      check("lit_branch_opc", 32'(w[6:0]), 32'(OPC_BRANCH));
      tick();
      bus.pc_in = 6; #1;
      check("lit_misaligned_nop", bus.instruction, 32'h00000013);
      tick();
      check("lit_misaligned_fault", 32'(bus.fault), 32'd1);
      check("lit_still_run", 32'(bus.core_rst), 32'd0);
      bus.pc_in = 0;
      for (int i = 0; i < 20 && !finished; i++) tick();
      // cycle budget with pc held at 0
      bus.start = 1; tick(); bus.start = 0;
      for (int i = 0; i < 7; i++) tick();
      check("lit_budget_not_yet", 32'(bus.done), 32'd0);
      check("lit_budget_cycles7", 32'(bus.run_cycles), 32'd7);
      tick();
      check("lit_budget_done", 32'(bus.done), 32'd1);
      check("lit_budget_hold7", 32'(bus.run_cycles), 32'd7);
      // start and clear together
      bus.start = 1; bus.clear = 1; tick(); bus.start = 0; bus.clear = 0;
      check("lit_clear_words", 32'(bus.words_loaded), 32'd0);
      check("lit_clear_ready", 32'(bus.load_ready), 32'd1);
      check("lit_clear_fault", 32'(bus.fault), 32'd0);
      // full memory then overflow
      bus.load_valid = 1;
      for (int i = 0; i < 256; i++) begin bus.load_data = $urandom; tick(); end
      check("lit_full_words", 32'(bus.words_loaded), 32'd256);
      check("lit_full_ready", 32'(bus.load_ready), 32'd0);
      check("lit_full_nofault", 32'(bus.fault), 32'd0);
      tick();
      bus.load_valid = 0;
      check("lit_overflow_fault", 32'(bus.fault), 32'd1);
      check("lit_overflow_ready", 32'(bus.load_ready), 32'd0);
      bus.start = 1; tick(); bus.start = 0;
      for (int i = 0; i < 3; i++) begin bus.pc_in = 32'(4 * $urandom_range(0, 255)); tick(); end
      // reset in the middle of a run
      rst = 1; tick(); rst = 0;
      bus.pc_in = 8; #1;
      check("lit_rst_instr", bus.instruction, 32'h00000013);
      check("lit_rst_core_rst", 32'(bus.core_rst), 32'd1);
      check("lit_rst_cycles", 32'(bus.run_cycles), 32'd0);
      check("lit_rst_words", 32'(bus.words_loaded), 32'd0);
      // random traffic
      for (int it = 0; it < 40; it++) begin
         int len, sent;
         len = $urandom_range(1, 20);
         sent = 0;
         bus.clear = 1; tick(); bus.clear = 0;
         for (int c = 0; c < 200 && sent < len; c++) begin
            bus.load_valid = ($urandom % 4) != 0;
            bus.load_data = $urandom;
            bus.load_last = (sent == len - 1);
            bus.start = ($urandom % 10) == 0;
            tick();
            if (bus.load_valid) sent++;
         end
         bus.load_valid = ($urandom % 5) == 0; bus.load_last = 0; bus.start = 0;
         tick();
         bus.load_valid = 0;
         for (int r = 0; r < 3; r++) begin
            bus.start = 1; tick(); bus.start = 0;
            for (int c = 0; c < 20 && running; c++) begin
               int s;
               s = $urandom % 10;
               bus.pc_in = s < 7 ? 32'(4 * $urandom_range(0, len - 1)) :
                           s == 7 ? 32'(4 * len) :
                           s == 8 ? 32'(4 * $urandom_range(0, len - 1) + $urandom_range(1, 3)) :
                           32'h0001_0000 | 32'(4 * $urandom_range(0, len - 1));
               bus.start = ($urandom % 8) == 0;
               bus.clear = ($urandom % 40) == 0;
               tick();
               bus.start = 0; bus.clear = 0;
            end
            if (running) begin
               failures++;
               $display("FAIL run_bound: run did not end within 20 cycles");
            end
         end
      end
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
